// File: rtl/mdu_pkg.sv
// Shared types and constants for the HI/LO divide sequencer.
package mdu_pkg;

  localparam int DW_DEF = 32;
  localparam int CW_DEF = 6;

  // Wide enough for any practical DW; users slice [DW-1:0].
  localparam logic [63:0] LO_DIV0 = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mdu_div_core.sv
// Restoring divider datapath: operand magnitudes, one quotient bit per step,
// and sign/div-by-zero fix-up into the HI (remainder) / LO (quotient) result.
module mdu_div_core
  import mdu_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic          fix,
  input  logic          is_signed,
  input  logic [DW-1:0] op_a,
  input  logic [DW-1:0] op_b,
  output logic [DW-1:0] hi_out,
  output logic [DW-1:0] lo_out
);

  logic [DW-1:0] rem_q, rem_d, dvd_q, dvd_d, dvs_q, dvs_d, a_q, a_d;
  logic [DW-1:0] hi_q, hi_d, lo_q, lo_d;
  logic          sgn_q, sgn_d, sa_q, sa_d, sb_q, sb_d, div0_q, div0_d;
  logic [DW:0]   shifted;
  logic          ge;

  // Quotient bits shift into the dividend register as it empties.
  assign shifted = {rem_q, dvd_q[DW-1]};
  assign ge      = (shifted >= {1'b0, dvs_q});

  always_comb begin
    rem_d  = rem_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    a_d    = a_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    sgn_d  = sgn_q;
    sa_d   = sa_q;
    sb_d   = sb_q;
    div0_d = div0_q;
    if (load) begin
      sgn_d  = is_signed;
      sa_d   = op_a[DW-1];
      sb_d   = op_b[DW-1];
      div0_d = (op_b == '0);
      a_d    = op_a;
      dvd_d  = (is_signed && op_a[DW-1]) ? -op_a : op_a;
      dvs_d  = (is_signed && op_b[DW-1]) ? -op_b : op_b;
      rem_d  = '0;
    end else if (step) begin
      if (ge) begin
        rem_d = shifted[DW-1:0] - dvs_q;
        dvd_d = {dvd_q[DW-2:0], 1'b1};
      end else begin
        rem_d = shifted[DW-1:0];
        dvd_d = {dvd_q[DW-2:0], 1'b0};
      end
    end else if (fix) begin
      if (div0_q) begin
        lo_d = LO_DIV0[DW-1:0];
        hi_d = a_q;
      end else begin
        lo_d = (sgn_q && (sa_q ^ sb_q)) ? -dvd_q : dvd_q;
        hi_d = (sgn_q && sa_q) ? -rem_q : rem_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      a_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      sgn_q  <= 1'b0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      div0_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      a_q    <= a_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      sgn_q  <= sgn_d;
      sa_q   <= sa_d;
      sb_q   <= sb_d;
      div0_q <= div0_d;
    end
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: rtl/mdu_div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer with pipeline stall and one-shot HI/LO write.
// Optional MDU_DIV0_FAST_EN: divide-by-zero skips the iterative phase.
//   state | meaning
//   IDLE  | waiting for an accepted start
//   CALC  | one restoring step per cycle, DW steps
//   FIX   | sign / div0 correction, results registered
//   DONE  | hilo_we pulse, then back to IDLE
module mdu_div_ctrl
  import mdu_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          is_signed,
  input  logic [DW-1:0] op_a,
  input  logic [DW-1:0] op_b,
  input  logic          flush,
  input  logic          hl_rd_req,
  input  logic          hl_wr_req,
  output logic          busy,
  output logic          stall,
  output logic          hilo_we,
  output logic [DW-1:0] hi_out,
  output logic [DW-1:0] lo_out
);

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          load, step, fix;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    load    = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          load    = 1'b1;
          count_d = '0;
`ifdef MDU_DIV0_FAST_EN
          state_d = (op_b == '0) ? ST_FIX : ST_CALC;
`else
          state_d = ST_CALC;
`endif
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          step    = 1'b1;
          count_d = count_q + 1'b1;
          if (count_q == CW'(DW - 1)) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          fix     = 1'b1;
          state_d = ST_DONE;
        end
      end
      // Flush is ignored here: the owning instruction has already left EX.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign hilo_we = (state_q == ST_DONE);
  assign stall   = busy & (hl_rd_req | hl_wr_req | start);

  mdu_div_core #(.DW(DW)) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .fix       (fix),
    .is_signed (is_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .hi_out    (hi_out),
    .lo_out    (lo_out)
  );

endmodule
